// File: rtl/data_mem_ctrl_if.sv
// Data memory request/response bus between a load/store unit and data_mem_ctrl.
// Signals: req/we/funct3/addr/wd (request), rd/ready/busy/err (response).
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
    logic [31:0]       rd;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output req, we, funct3, addr, wd,
        input  rd, ready, busy, err
    );

    modport slave (
        input  req, we, funct3, addr, wd,
        output rd, ready, busy, err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I data memory controller: IDLE/WAIT/RESP FSM over a word array with byte lanes.
// Ports: clk, rst_n (async active-low), bus (data_mem_ctrl_if.slave).
// Parameters: ADDR_W byte-address width, DEPTH word count, LATENCY wait cycles (0..7).
// Macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses flag err instead of aligning.
module data_mem_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_ctrl_if.slave bus
);
    localparam int                IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [2:0]        LAT_C   = 3'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wd_q;
    logic [31:0]       rd_q, rd_d;
    logic              err_q;

    logic [31:0]       mem [DEPTH];

    logic              op_we;
    logic [2:0]        op_f3;
    logic [ADDR_W-1:0] op_a, ea;
    logic [31:0]       op_wd;
    logic              illegal, misal, oor, bad, commit;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        be;
    logic [31:0]       wdata, word;
    logic [7:0]        bsel;
    logic [15:0]       hsel;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = LAT_C;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=0 the access completes straight from IDLE, before the
    // captured copy exists, so the live bus is used in that case.
    always_comb begin
        op_we = (state_q == IDLE) ? bus.we     : we_q;
        op_f3 = (state_q == IDLE) ? bus.funct3 : f3_q;
        op_a  = (state_q == IDLE) ? bus.addr   : addr_q;
        op_wd = (state_q == IDLE) ? bus.wd     : wd_q;

        illegal = (op_f3 == 3'b011) || (op_f3[2:1] == 2'b11)
               || (op_we && op_f3[2]);
        ea    = op_a;
        misal = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        misal = ((op_f3[1:0] == 2'b01) && op_a[0])
             || ((op_f3[1:0] == 2'b10) && (op_a[1:0] != 2'b00));
`else
        if (op_f3[1:0] == 2'b01) ea[0]   = 1'b0;
        if (op_f3[1:0] == 2'b10) ea[1:0] = 2'b00;
`endif
        oor    = {2'b00, op_a[ADDR_W-1:2]} >= DEPTH_A;
        bad    = illegal || misal || oor;
        idx    = op_a[IDX_W+1:2];
        commit = (state_d == RESP) && rst_n;

        be    = 4'b0000;
        wdata = op_wd;
        unique case (op_f3[1:0])
            2'b00: begin
                be    = 4'b0001 << ea[1:0];
                wdata = {4{op_wd[7:0]}};
            end
            2'b01: begin
                be    = ea[1] ? 4'b1100 : 4'b0011;
                wdata = {2{op_wd[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase

        word = mem[idx];
        bsel = word[{ea[1:0], 3'b000} +: 8];
        hsel = ea[1] ? word[31:16] : word[15:0];

        rd_d = 32'd0;
        if (!op_we && !bad) begin
            unique case (op_f3)
                3'b000:  rd_d = {{24{bsel[7]}}, bsel};
                3'b001:  rd_d = {{16{hsel[15]}}, hsel};
                3'b010:  rd_d = word;
                3'b100:  rd_d = {24'd0, bsel};
                3'b101:  rd_d = {16'd0, hsel};
                default: rd_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wd_q    <= 32'd0;
            rd_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= commit && bad;
            if (state_q == IDLE && bus.req) begin
                we_q   <= bus.we;
                f3_q   <= bus.funct3;
                addr_q <= bus.addr;
                wd_q   <= bus.wd;
            end
            if (commit) rd_q <= rd_d;
        end
    end

    // Array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (commit && op_we && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign bus.rd    = rd_q;
    assign bus.ready = (state_q == RESP);
    assign bus.busy  = (state_q != IDLE);
    assign bus.err   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (LATENCY=2 and LATENCY=0 instances).
// Honors DMEM_MISALIGN_TRAP_EN for the misalignment expectations.
module tb_data_mem_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   ncmp  = 0;
    int   nfail = 0;
    logic trap;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(16)) b2 ();
    data_mem_ctrl_if #(.ADDR_W(16)) b0 ();

    data_mem_ctrl #(.ADDR_W(16), .DEPTH(1024), .LATENCY(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    data_mem_ctrl #(.ADDR_W(16), .DEPTH(1024), .LATENCY(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input string tag, input logic w, input logic [2:0] f,
                      input logic [15:0] a, input logic [31:0] d,
                      input logic [31:0] xr, input logic xe);
        int          cyc;
        logic [31:0] r;
        logic        e;
        @(negedge clk);
        b2.req    = 1'b1;
        b2.we     = w;
        b2.funct3 = f;
        b2.addr   = a;
        b2.wd     = d;
        @(posedge clk);
        #1;
        b2.req = 1'b0;
        cyc = 0;
        r   = '0;
        e   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (b2.ready) begin
                cyc = i;
                r   = b2.rd;
                e   = b2.err;
                break;
            end
        end
        chk({tag, ".lat"}, cyc, 32'd3);
        chk({tag, ".rd"}, r, xr);
        chk({tag, ".err"}, {31'd0, e}, {31'd0, xe});
    endtask

    initial begin
`ifdef DMEM_MISALIGN_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        rst_n = 1'b0;
        b2.req = 1'b0; b2.we = 1'b0; b2.funct3 = 3'd0;
        b2.addr = '0;  b2.wd = '0;
        b0.req = 1'b0; b0.we = 1'b0; b0.funct3 = 3'd0;
        b0.addr = '0;  b0.wd = '0;
        repeat (2) @(negedge clk);
        chk("rst.rd", b2.rd, 32'd0);
        chk("rst.ready", {31'd0, b2.ready}, 32'd0);
        chk("rst.busy", {31'd0, b2.busy}, 32'd0);
        chk("rst.err", {31'd0, b2.err}, 32'd0);
        rst_n = 1'b1;

        op("sw28", 1, 3'b010, 16'h0028, 32'h0000_0012, 32'h0, 0);
        op("lw28", 0, 3'b010, 16'h0028, 32'h0, 32'h0000_0012, 0);

        op("sw14", 1, 3'b010, 16'h0014, 32'h0000_F00F, 32'h0, 0);
        op("sb15", 1, 3'b000, 16'h0015, 32'h0000_00AB, 32'h0, 0);
        op("lb15", 0, 3'b000, 16'h0015, 32'h0, 32'hFFFF_FFAB, 0);
        op("lbu15", 0, 3'b100, 16'h0015, 32'h0, 32'h0000_00AB, 0);
        op("lw14", 0, 3'b010, 16'h0014, 32'h0, 32'h0000_AB0F, 0);

        op("sw54", 1, 3'b010, 16'h0054, 32'h0, 32'h0, 0);
        op("sh56", 1, 3'b001, 16'h0056, 32'h0000_8ABC, 32'h0, 0);
        op("lh56", 0, 3'b001, 16'h0056, 32'h0, 32'hFFFF_8ABC, 0);
        op("lhu56", 0, 3'b101, 16'h0056, 32'h0, 32'h0000_8ABC, 0);
        op("lw54", 0, 3'b010, 16'h0054, 32'h0, 32'h8ABC_0000, 0);

        repeat (3) @(negedge clk);
        chk("rdhold", b2.rd, 32'h8ABC_0000);
        chk("idle.ready", {31'd0, b2.ready}, 32'd0);

        op("sw16mis", 1, 3'b010, 16'h0016, 32'hDEAD_BEEF, 32'h0, trap);
        op("lw14b", 0, 3'b010, 16'h0014, 32'h0,
           trap ? 32'h0000_AB0F : 32'hDEAD_BEEF, 0);
        op("lh57mis", 0, 3'b001, 16'h0057, 32'h0,
           trap ? 32'h0 : 32'hFFFF_8ABC, trap);

        op("ld011", 0, 3'b011, 16'h0028, 32'h0, 32'h0, 1);
        op("ld110", 0, 3'b110, 16'h0028, 32'h0, 32'h0, 1);
        op("st100", 1, 3'b100, 16'h0028, 32'h0000_0077, 32'h0, 1);
        op("lw28b", 0, 3'b010, 16'h0028, 32'h0, 32'h0000_0012, 0);

        op("sw00", 1, 3'b010, 16'h0000, 32'h0000_005A, 32'h0, 0);
        op("sw1000", 1, 3'b010, 16'h1000, 32'h0000_00FF, 32'h0, 1);
        op("lw1000", 0, 3'b010, 16'h1000, 32'h0, 32'h0, 1);
        op("lw00", 0, 3'b010, 16'h0000, 32'h0, 32'h0000_005A, 0);
        op("sw0ffc", 1, 3'b010, 16'h0FFC, 32'h1234_5678, 32'h0, 0);
        op("lw0ffc", 0, 3'b010, 16'h0FFC, 32'h0, 32'h1234_5678, 0);

        op("lw28c", 0, 3'b010, 16'h0028, 32'h0, 32'h0000_0012, 0);
        @(negedge clk);
        b2.req = 1'b1; b2.we = 1'b1; b2.funct3 = 3'b010;
        b2.addr = 16'h0028; b2.wd = 32'h0000_0099;
        @(posedge clk);
        #1;
        b2.req = 1'b0;
        @(negedge clk);
        chk("wait.busy", {31'd0, b2.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst.busy", {31'd0, b2.busy}, 32'd0);
        chk("arst.ready", {31'd0, b2.ready}, 32'd0);
        chk("arst.rd", b2.rd, 32'd0);
        chk("arst.err", {31'd0, b2.err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op("lw28d", 0, 3'b010, 16'h0028, 32'h0, 32'h0000_0012, 0);

        @(negedge clk);
        b0.req = 1'b1; b0.we = 1'b1; b0.funct3 = 3'b010;
        b0.addr = 16'h0000; b0.wd = 32'h0000_0005;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("l0.ready%0d", k), {31'd0, b0.ready},
                {31'd0, k[0]});
            chk($sformatf("l0.busy%0d", k), {31'd0, b0.busy},
                {31'd0, k[0]});
        end
        b0.we = 1'b0;
        @(posedge clk);
        #1;
        b0.req = 1'b0;
        @(negedge clk);
        chk("l0.ldready", {31'd0, b0.ready}, 32'd1);
        chk("l0.ldrd", b0.rd, 32'h0000_0005);
        chk("l0.lderr", {31'd0, b0.err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width.
REQ-002 Parameter DEPTH, default 1024, 32-bit word count; power of two; DEPTH*4 <= 2^ADDR_W.
REQ-003 Parameter LATENCY, default 1, wait cycles inserted before response; range 0..7.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low; single clock domain.
REQ-006 req  input  1  access request, sampled in IDLE only.
REQ-007 we  input  1  1 = store, 0 = load.
REQ-008 funct3  input  3  RV32I size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 addr  input  ADDR_W  byte address.
REQ-010 wd  input  32  store data, right-aligned.
REQ-011 rd  output  32  load data, extended to 32 bits.
REQ-012 ready  output  1  one-cycle response strobe.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 err  output  1  error flag, valid with ready.

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 IDLE with req=1 at clock edge: capture we/funct3/addr/wd; next state WAIT with counter=LATENCY if LATENCY>0, else RESP.
REQ-017 WAIT: counter decrements each cycle; at counter==1, next state RESP.
REQ-018 Result: ready=1 for exactly one cycle, LATENCY+1 cycles after the accepting edge; RESP always returns to IDLE.
REQ-019 req is ignored in WAIT and RESP; next request is accepted no earlier than the cycle after RESP.
REQ-020 Store commits to the array on the edge entering RESP.
REQ-021 Store byte lanes: SB (000) writes lane addr[1:0]; SH (001) writes lanes {addr[1],0} and {addr[1],1}; SW (010) writes all four; other lanes are unchanged.
REQ-022 Load data is selected from captured address lanes.
REQ-023 Load extension: LB (000) and LH (001) sign-extend; LBU (100) and LHU (101) zero-extend; LW (010) returns the full word.
REQ-024 rd is registered and holds its value until the next RESP; rd=0 after a store RESP.
REQ-025 funct3 in {011,110,111}, or stores with funct3 in {100,101}, are illegal: err=1, no write, rd=0.
REQ-026 Word index addr[ADDR_W-1:2] >= DEPTH is out of range: err=1, no write, rd=0.
REQ-027 err is cleared in every non-RESP cycle.
REQ-028 Load after store to the same word, issued in the next accepted request, returns the new data.

Reset
REQ-029 rst_n=0 forces immediately: state IDLE, counter 0, ready 0, busy 0, err 0, rd 0.
REQ-030 Memory array is not reset; contents are retained.
REQ-031 Reset during WAIT drops the pending store with no array change.

Configuration
REQ-032 Macro DMEM_MISALIGN_TRAP_EN defined: halfword access with addr[0]=1, or word access with addr[1:0]!=0, gives err=1, no write, rd=0.
REQ-033 DMEM_MISALIGN_TRAP_EN undefined: alignment is forced by ignoring addr[0] for halfwords and addr[1:0] for words, and misalignment never sets err.

Verification
REQ-034 LATENCY=2: SW addr=0x0028 wd=0x00000012, then LW 0x0028 -> ready exactly 3 cycles after each accept; rd=0x00000012, err=0.
REQ-035 SW 0x0014 wd=0x0000F00F, then SB 0x0015 wd=0xAB, then LB 0x0015 -> rd=0xFFFFFFAB; LBU -> 0x000000AB; LW -> 0x0000ABOF (word 0x0000AB0F).
REQ-036 SH 0x0056 wd=0x8ABC, then LH 0x0056 -> rd=0xFFFF8ABC; LHU -> 0x00008ABC; LW 0x0054 -> 0x8ABC0000 (lower half previously 0).
REQ-037 With trap enabled: SW 0x0016 -> err=1, word 0x0014 unchanged; without trap: same SW writes word 0x0014, err=0.
REQ-038 Depth and reset: LW 0x1000 with DEPTH=1024 -> err=1, rd=0; SW asserted, then rst_n pulsed low in WAIT -> outputs zero immediately, later LW shows old data.
REQ-039 req held high continuously with LATENCY=0 -> accepts every 2nd cycle, busy toggles, ready pulses alternate cycles.
